// File: rtl/corr_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// corr_coeff_ctrl
//
// Purpose:
//    Loads a bank of NUM_COEFF coefficients into an inactive correlator bank.
//    When the load completes, the controller waits for the next frame boundary
//    and then switches the active bank, so the correlator never sees a
//    half-written bank.
//
// Optional feature:
//    CORR_COEFF_CTRL_CHECKSUM_EN - when defined, a 9-bit modulo-512 sum of
//    all loaded beats is kept, and one extra beat is accepted after the last
//    coefficient. The bank is armed only if that beat equals the sum.
//    Otherwise err is set and the active bank is left as it was.
//
// Parameters:
//    NUM_COEFF   coefficients per bank load (1..256)
//
// Ports:
//    clk          in   1  rising-edge clock
//    reset        in   1  synchronous active-high reset
//    load_start   in   1  request to start loading bank load_bank
//    load_bank    in   2  target bank, sampled when load_start is accepted
//    load_valid   in   1  load_data beat valid
//    load_data    in   9  coefficient beat
//    load_ready   out  1  a beat is accepted this cycle
//    frame_sync   in   1  frame-boundary pulse from the correlator
//    coeff_index  out  8  coefficient write address
//    coeff_value  out  9  coefficient write data
//    coeff_write  out  1  coefficient write strobe
//    coeff_sel    out  2  active coefficient bank
//    busy         out  1  controller is not idle
//    done         out  1  pulse in the cycle coeff_sel changes
//    err          out  1  sticky error, cleared by the next accepted load_start
// -----------------------------------------------------------------------------
module corr_coeff_ctrl #(
   parameter int NUM_COEFF = 192
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_start,
   input  logic [1:0] load_bank,
   input  logic       load_valid,
   input  logic [8:0] load_data,
   output logic       load_ready,
   input  logic       frame_sync,
   output logic [7:0] coeff_index,
   output logic [8:0] coeff_value,
   output logic       coeff_write,
   output logic [1:0] coeff_sel,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [7:0] LAST_IDX = 8'(NUM_COEFF - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_CHECK = 2'd2,
      S_ARMED = 2'd3
   } state_t;

   state_t     r_state,       w_state_nxt;
   logic [1:0] r_bank,        w_bank_nxt;
   logic [7:0] r_cnt,         w_cnt_nxt;
   logic       r_load_ready,  w_load_ready_nxt;
   logic [7:0] r_coeff_index, w_coeff_index_nxt;
   logic [8:0] r_coeff_value, w_coeff_value_nxt;
   logic       r_coeff_write, w_coeff_write_nxt;
   logic [1:0] r_coeff_sel,   w_coeff_sel_nxt;
   logic       r_busy,        w_busy_nxt;
   logic       r_done,        w_done_nxt;
   logic       r_err,         w_err_nxt;
   logic       w_xfer;
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
   logic [8:0] r_sum,         w_sum_nxt;
`endif

   // load_ready is registered, so it already reflects whether the current
   // state takes beats.
   assign w_xfer = load_valid && r_load_ready;

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt       = r_state;
      w_bank_nxt        = r_bank;
      w_cnt_nxt         = r_cnt;
      w_coeff_index_nxt = r_coeff_index;
      w_coeff_value_nxt = r_coeff_value;
      w_coeff_write_nxt = 1'b0;
      w_coeff_sel_nxt   = r_coeff_sel;
      w_done_nxt        = 1'b0;
      w_err_nxt         = r_err;
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
      w_sum_nxt         = r_sum;
`endif

      case (r_state)
         S_IDLE: begin
            if (load_start) begin
               // The active bank must never be overwritten while in use.
               if (load_bank != r_coeff_sel) begin
                  w_state_nxt = S_LOAD;
                  w_bank_nxt  = load_bank;
                  w_cnt_nxt   = 8'd0;
                  w_err_nxt   = 1'b0;
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
                  w_sum_nxt   = 9'd0;
`endif
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end

         S_LOAD: begin
            if (w_xfer) begin
               w_coeff_write_nxt = 1'b1;
               w_coeff_index_nxt = r_cnt;
               w_coeff_value_nxt = load_data;
               w_cnt_nxt         = r_cnt + 8'd1;
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
               w_sum_nxt         = r_sum + load_data;
`endif
               if (r_cnt == LAST_IDX) begin
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
                  w_state_nxt = S_CHECK;
`else
                  w_state_nxt = S_ARMED;
`endif
               end
            end
         end

         S_CHECK: begin
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
            // The checksum beat is consumed but never written.
            if (w_xfer) begin
               if (load_data == r_sum) begin
                  w_state_nxt = S_ARMED;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_err_nxt   = 1'b1;
               end
            end
`else
            w_state_nxt = S_IDLE;
`endif
         end

         S_ARMED: begin
            // Only pulses seen while already in ARMED trigger the swap; a
            // pulse coinciding with the final beat was evaluated in LOAD.
            if (frame_sync) begin
               w_coeff_sel_nxt = r_bank;
               w_done_nxt      = 1'b1;
               w_state_nxt     = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_load_ready_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_CHECK);
      w_busy_nxt       = (w_state_nxt != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // State and control registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= 8'd0;
         r_load_ready  <= 1'b0;
         r_coeff_write <= 1'b0;
         r_coeff_sel   <= 2'd0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_load_ready  <= w_load_ready_nxt;
         r_coeff_write <= w_coeff_write_nxt;
         r_coeff_sel   <= w_coeff_sel_nxt;
         r_busy        <= w_busy_nxt;
         r_done        <= w_done_nxt;
         r_err         <= w_err_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Data registers: qualified by coeff_write or by state, so no reset needed
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      r_bank        <= w_bank_nxt;
      r_coeff_index <= w_coeff_index_nxt;
      r_coeff_value <= w_coeff_value_nxt;
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
      r_sum         <= w_sum_nxt;
`endif
   end

   assign load_ready  = r_load_ready;
   assign coeff_index = r_coeff_index;
   assign coeff_value = r_coeff_value;
   assign coeff_write = r_coeff_write;
   assign coeff_sel   = r_coeff_sel;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;

endmodule

// File: tb/tb_corr_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// tb_corr_coeff_ctrl
//
// Bench for corr_coeff_ctrl. Expected coefficient writes go into a queue as
// beats are offered; a monitor pops and compares on every coeff_write.
// Define CORR_COEFF_CTRL_CHECKSUM_EN to build against the checksum variant.
// -----------------------------------------------------------------------------
module tb_corr_coeff_ctrl;

   localparam int N = 192;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load_start = 1'b0;
   logic [1:0] load_bank = 2'd0;
   logic       load_valid = 1'b0;
   logic [8:0] load_data = 9'd0;
   logic       load_ready;
   logic       frame_sync = 1'b0;
   logic [7:0] coeff_index;
   logic [8:0] coeff_value;
   logic       coeff_write;
   logic [1:0] coeff_sel;
   logic       busy;
   logic       done;
   logic       err;

   int n_checks = 0;
   int n_fail   = 0;
   int done_seen = 0;
   int exp_done  = 0;
   logic [16:0] sb_q[$];
   logic [16:0] mon_exp;

   corr_coeff_ctrl #(.NUM_COEFF(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_start  (load_start),
      .load_bank   (load_bank),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .frame_sync  (frame_sync),
      .coeff_index (coeff_index),
      .coeff_value (coeff_value),
      .coeff_write (coeff_write),
      .coeff_sel   (coeff_sel),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Write monitor / scoreboard consumer, sampling on the falling edge.
   always @(negedge clk) begin
      if (coeff_write !== 1'b0) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: write=%b index=%0d value=%0d, required no write",
                     coeff_write, coeff_index, coeff_value);
         end else begin
            mon_exp = sb_q.pop_front();
            if ({coeff_index, coeff_value} !== mon_exp) begin
               n_fail++;
               $display("FAIL write_data: index=%0d value=%0d, required index=%0d value=%0d",
                        coeff_index, coeff_value, mon_exp[16:9], mon_exp[8:0]);
            end
         end
      end
      if (done === 1'b1) done_seen++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   task automatic check_sel(input string name, input logic [1:0] req);
      n_checks++;
      if (coeff_sel !== req) begin
         n_fail++;
         $display("FAIL %s: coeff_sel=%0d, required %0d", name, coeff_sel, req);
      end
   endtask

   task automatic check_done_count(input string name);
      n_checks++;
      if (done_seen !== exp_done) begin
         n_fail++;
         $display("FAIL %s: done pulses=%0d, required %0d", name, done_seen, exp_done);
      end
   endtask

   task automatic start_load(input logic [1:0] bank);
      load_start = 1'b1;
      load_bank  = bank;
      step();
      load_start = 1'b0;
   endtask

   // Offer one beat and hold it until load_ready accepts it (bounded).
   task automatic send_beat(input logic [8:0] v, input bit wr, input logic [7:0] idx);
      int t;
      bit ok;
      t  = 0;
      ok = 1'b0;
      load_valid = 1'b1;
      load_data  = v;
      while (!ok && t < 50) begin
         ok = (load_ready === 1'b1);
         if (ok && wr) sb_q.push_back({idx, v});
         step();
         t++;
      end
      load_valid = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL beat_accept: beat %0d not accepted within %0d cycles, required accept", idx, t);
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 10) begin
         step();
         t++;
      end
      step();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d writes outstanding, required 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic pulse_frame_sync();
      frame_sync = 1'b1;
      step();
      frame_sync = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      check_sel("reset_sel", 2'd0);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_err", err, 1'b0);
      check_bit("reset_done", done, 1'b0);
      check_bit("reset_ready", load_ready, 1'b0);
      check_bit("reset_write", coeff_write, 1'b0);
      // Idle with stray load_valid and frame_sync: must produce nothing.
      for (int i = 0; i < 10; i++) begin
         load_valid = i[0];
         load_data  = 9'(i);
         frame_sync = (i == 4);
         step();
      end
      load_valid = 1'b0;
      frame_sync = 1'b0;
      check_bit("idle_busy", busy, 1'b0);
      check_bit("idle_err", err, 1'b0);
      check_sel("idle_sel", 2'd0);
      check_done_count("idle_done");
   endtask

   task automatic test_same_bank_err();
      start_load(2'd0);
      check_bit("samebank_err", err, 1'b1);
      check_bit("samebank_busy", busy, 1'b0);
      check_bit("samebank_ready", load_ready, 1'b0);
      load_valid = 1'b1;
      load_data  = 9'h1AA;
      repeat (3) step();
      load_valid = 1'b0;
      check_bit("samebank_err_sticky", err, 1'b1);
      check_sel("samebank_sel", 2'd0);
   endtask

   task automatic test_full_load();
      logic [8:0] sum;
      sum = 9'd0;
      start_load(2'd1);
      check_bit("full_err_cleared", err, 1'b0);
      check_bit("full_busy", busy, 1'b1);
      check_bit("full_ready", load_ready, 1'b1);
      for (int i = 0; i < N; i++) begin
         // A pulse coinciding with the last beat must not cause the swap.
         frame_sync = (i == N - 1);
         send_beat(9'(i), 1'b1, 8'(i));
         frame_sync = 1'b0;
         sum = sum + 9'(i);
      end
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
      send_beat(sum, 1'b0, 8'd0);
`endif
      wait_drain("full_drain");
      repeat (3) step();
      check_bit("full_armed_busy", busy, 1'b1);
      check_bit("full_armed_ready", load_ready, 1'b0);
      check_sel("full_no_early_swap", 2'd0);
      check_done_count("full_no_early_done");
      pulse_frame_sync();
      exp_done++;
      check_bit("full_done_pulse", done, 1'b1);
      check_sel("full_swap_sel", 2'd1);
      check_bit("full_idle_busy", busy, 1'b0);
      step();
      check_bit("full_done_one_cycle", done, 1'b0);
      check_done_count("full_done_count");
   endtask

   task automatic test_reset_mid_load();
      start_load(2'd2);
      for (int i = 0; i <= 100; i++) begin
         send_beat(9'($urandom_range(0, 511)), 1'b1, 8'(i));
      end
      wait_drain("midreset_drain");
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      check_sel("midreset_sel", 2'd0);
      check_bit("midreset_busy", busy, 1'b0);
      check_bit("midreset_ready", load_ready, 1'b0);
      pulse_frame_sync();
      step();
      check_sel("midreset_no_swap", 2'd0);
      check_done_count("midreset_no_done");
   endtask

   task automatic test_throttled();
      logic [8:0] v;
      logic [8:0] sum;
      sum = 9'd0;
      start_load(2'd2);
      for (int i = 0; i < N; i++) begin
         v = 9'($urandom_range(0, 511));
         send_beat(v, 1'b1, 8'(i));
         sum = sum + v;
         if (i == 50) begin
            // Would be a same-bank error in IDLE; while busy it is ignored.
            load_start = 1'b1;
            load_bank  = 2'd0;
         end
         if (i < N - 1) begin
            frame_sync = 1'b1;
            step();
            load_start = 1'b0;
            frame_sync = 1'b0;
         end
      end
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
      send_beat(sum, 1'b0, 8'd0);
`endif
      wait_drain("throttle_drain");
      check_bit("throttle_busy_start_no_err", err, 1'b0);
      check_bit("throttle_armed_busy", busy, 1'b1);
      check_sel("throttle_no_early_swap", 2'd0);
      check_done_count("throttle_no_early_done");
      pulse_frame_sync();
      exp_done++;
      check_bit("throttle_done_pulse", done, 1'b1);
      check_sel("throttle_swap_sel", 2'd2);
      step();
      check_done_count("throttle_done_count");
   endtask

`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
   task automatic test_checksum();
      start_load(2'd3);
      for (int i = 0; i < N; i++) send_beat(9'd1, 1'b1, 8'(i));
      send_beat(9'd191, 1'b0, 8'd0);
      wait_drain("cksum_bad_drain");
      check_bit("cksum_bad_err", err, 1'b1);
      check_bit("cksum_bad_busy", busy, 1'b0);
      pulse_frame_sync();
      step();
      check_sel("cksum_bad_no_swap", 2'd2);
      check_done_count("cksum_bad_no_done");

      start_load(2'd3);
      check_bit("cksum_err_cleared", err, 1'b0);
      for (int i = 0; i < N; i++) send_beat(9'd1, 1'b1, 8'(i));
      send_beat(9'd192, 1'b0, 8'd0);
      wait_drain("cksum_good_drain");
      check_bit("cksum_good_err", err, 1'b0);
      check_bit("cksum_good_busy", busy, 1'b1);
      pulse_frame_sync();
      exp_done++;
      check_bit("cksum_good_done", done, 1'b1);
      check_sel("cksum_good_swap", 2'd3);
      step();
      check_done_count("cksum_done_count");
   endtask
`endif

   initial begin
      test_reset();
      test_same_bank_err();
      test_full_load();
      test_reset_mid_load();
      test_throttled();
`ifdef CORR_COEFF_CTRL_CHECKSUM_EN
      test_checksum();
`endif
      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/corr_coeff_ctrl.md
CORR_COEFF_CTRL -- requirements
Module: corr_coeff_ctrl

Interface
REQ-001 Parameter NUM_COEFF, 192, coefficients per bank load (1..256).
REQ-002 Clock clk; reset reset, synchronous, active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 load_start  input  1  one-cycle request to begin loading bank load_bank.
REQ-006 load_bank  input  2  target bank, sampled when load_start is accepted.
REQ-007 load_valid  input  1  load_data beat valid.
REQ-008 load_data  input  9  coefficient value beat.
REQ-009 load_ready  output  1  controller accepts a beat this cycle.
REQ-010 frame_sync  input  1  one-cycle pulse at correlator sequence wrap (frame boundary).
REQ-011 coeff_index  output  8  coefficient write address to the correlator.
REQ-012 coeff_value  output  9  coefficient write data.
REQ-013 coeff_write  output  1  coefficient write strobe.
REQ-014 coeff_sel  output  2  active coefficient bank driven to the correlator.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse when a bank swap takes effect.
REQ-017 err  output  1  sticky error flag; cleared by the next accepted load_start.

Function
REQ-018 FSM states are IDLE, LOAD, CHECK, ARMED; all outputs are registered.
REQ-019 IDLE: load_start with load_bank != coeff_sel moves to LOAD, latches the bank, clears the beat counter and clears err.
REQ-020 IDLE: load_start with load_bank == coeff_sel sets err and stays in IDLE (active bank is never written).
REQ-021 LOAD: load_ready = 1; a beat transfers when load_valid && load_ready.
REQ-022 Each transferred beat drives coeff_write = 1, coeff_index = beat count, and coeff_value = load_data on the following cycle; coeff_write is 0 otherwise.
REQ-023 Beat count is 8 bits; after beat NUM_COEFF-1 is transferred, LOAD moves to CHECK (macro set) or ARMED (macro clear).
REQ-024 load_start while busy is ignored; it sets no error and does not restart the load.
REQ-025 ARMED: on frame_sync, coeff_sel <= latched bank, done pulses the same cycle coeff_sel changes, and the FSM returns to IDLE.
REQ-026 frame_sync in the cycle the FSM enters ARMED is not used; the swap waits for the next pulse.
REQ-027 frame_sync in IDLE, LOAD or CHECK has no effect.
REQ-028 load_valid outside LOAD is ignored and no write is issued.

Reset
REQ-029 Reset forces IDLE, coeff_sel = 0, beat count = 0, and coeff_write, load_ready, busy, done and err all = 0.
REQ-030 Reset during LOAD or ARMED abandons the load with no swap; coefficients already written remain in the correlator.

Configuration
REQ-031 Macro CORR_COEFF_CTRL_CHECKSUM_EN enables load-integrity checking.
REQ-032 With the macro: a running 9-bit modulo-512 sum of all transferred coefficient beats is kept.
REQ-033 With the macro: in CHECK, load_ready = 1 and one extra beat is accepted but not written.
REQ-034 With the macro: if the extra beat equals the sum, go to ARMED; otherwise set err, return to IDLE, and leave coeff_sel unchanged.
REQ-035 Without the macro: CHECK is unreachable, there is no sum logic, and LOAD goes directly to ARMED.

Verification
REQ-036 Reset, then idle 10 cycles -> coeff_sel = 0, busy = 0, err = 0, coeff_write never high.
REQ-037 load_start bank 1, 192 back-to-back beats of value i, then frame_sync -> 192 writes with index i = value i, then coeff_sel = 1 and done pulse on the same cycle.
REQ-038 load_start with bank 0 while coeff_sel = 0 -> err = 1, busy = 0, no writes.
REQ-039 load_valid toggled every other cycle during LOAD -> one write per beat with contiguous indices 0..191; frame_sync pulses during LOAD are ignored.
REQ-040 Reset asserted after beat 100 of a bank-2 load -> IDLE, coeff_sel = 0, no done pulse.
REQ-041 Macro set, all beats = 1, checksum beat 191 -> err = 1 and no swap; repeat with checksum beat 192 mod 512 = 192 -> swap on the next frame_sync.
